// File: rtl/rv32im_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// rv32im_dmem_ctrl
//   Data-memory bus controller sitting between rv32im_lsu and the data bus.
//   Takes one load/store at a time, registers it, checks alignment, drives a
//   req/ack handshake (with optional timeout) and returns the raw aligned read
//   word to the LSU, which does its own sign/zero extraction.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   req_*                 LSU request (valid/ready, we, size, addr, wdata)
//   busy_o                pipeline stall, high whenever not IDLE
//   rsp_*                 one-cycle response pulse + held rdata/err/misalign
//   mem_*                 memory side: req/we/addr/be/wdata out, ack/rdata/err in
//
// rv32im_dmem_ctrl_lane
//   One byte lane of the write path: picks the store byte that lands in this
//   lane and decides whether the lane is enabled.
// -----------------------------------------------------------------------------

module rv32im_dmem_ctrl_lane #(
    parameter int unsigned LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        lane_be,
    output logic [7:0]  lane_data
);
    localparam logic [1:0] LANE_IDX  = 2'(LANE);
    localparam int unsigned HALF_SEL = LANE % 2;

    always_comb begin
        lane_be   = 1'b0;
        lane_data = wdata[8*LANE +: 8];
        case (size)
            2'b00: begin
                // byte replicated to every lane, only the addressed one enabled
                lane_data = wdata[7:0];
                lane_be   = (addr_lo == LANE_IDX);
            end
            2'b01: begin
                // half replicated to both halves; only aligned halves reach the bus
                lane_data = wdata[8*HALF_SEL +: 8];
                lane_be   = (addr_lo[1] == LANE_IDX[1]);
            end
            2'b10: begin
                lane_be = 1'b1;
            end
            default: begin
                lane_be = 1'b0;
            end
        endcase
    end
endmodule

module rv32im_dmem_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMO_W          = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    // LSU request
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    // pipeline / response
    output logic                  busy_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_misalign_o,
    // memory bus
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i
);
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned VEC_W     = 8;
    // Count value on the last allowed wait cycle; unused when timeout is off.
    localparam int unsigned TMO_LAST   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TMO_W-1:0] TMO_LAST_V = TMO_W'(TMO_LAST);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    typedef struct packed {
        logic                  we;
        logic [1:0]            size;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                            state, state_nxt;
    req_t                              req_q;
    logic [TMO_W-1:0]                  tmo_cnt;
    logic                              in_misalign;
    logic                              tmo_hit;
    logic                              in_bus;
    logic [DATA_WIDTH-1:0]             rsp_rdata_q;
    logic                              rsp_err_q;
    logic                              rsp_misalign_q;
    logic [NUM_LANES-1:0]              lane_be;
    logic [NUM_LANES-1:0][VEC_W-1:0]   lane_data;

    // Alignment check on the incoming request; size 11 is always rejected.
    always_comb begin
        case (req_size_i)
            2'b00:   in_misalign = 1'b0;
            2'b01:   in_misalign = req_addr_i[0];
            2'b10:   in_misalign = |req_addr_i[1:0];
            default: in_misalign = 1'b1;
        endcase
    end

    assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST_V);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid_i) state_nxt = in_misalign ? S_RESP : S_BUS;
            // an ack on the limit cycle still counts as normal completion
            S_BUS:  if (mem_ack_i || tmo_hit) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded straight from state so an async reset drops mem_req_o at once.
    always_comb begin
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        rsp_valid_o = 1'b0;
        in_bus      = 1'b0;
        case (state)
            S_IDLE: begin req_ready_o = 1'b1; busy_o = 1'b0; end
            S_BUS:  in_bus = 1'b1;
            S_RESP: rsp_valid_o = 1'b1;
            default: busy_o = 1'b1;
        endcase
    end

    // ---------------- request / response registers ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q          <= '0;
            tmo_cnt        <= '0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            rsp_misalign_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        req_q   <= '{we: req_we_i, size: req_size_i,
                                     addr: req_addr_i, wdata: req_wdata_i};
                        tmo_cnt <= '0;
                        if (in_misalign) begin
                            rsp_rdata_q    <= '0;
                            rsp_err_q      <= 1'b0;
                            rsp_misalign_q <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack_i) begin
                        rsp_rdata_q    <= req_q.we ? '0 : mem_rdata_i;
                        rsp_err_q      <= mem_err_i;
                        rsp_misalign_q <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_rdata_q    <= '0;
                        rsp_err_q      <= 1'b1;
                        rsp_misalign_q <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write path lanes ----------------
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        rv32im_dmem_ctrl_lane #(.LANE(g)) u_lane (
            .size      (req_q.size),
            .addr_lo   (req_q.addr[1:0]),
            .wdata     (req_q.wdata[31:0]),
            .lane_be   (lane_be[g]),
            .lane_data (lane_data[g])
        );
    end

    // Bus outputs are only driven in BUS and come from the registered request,
    // so they stay stable for the whole handshake.
    assign mem_req_o   = in_bus;
    assign mem_we_o    = in_bus & req_q.we;
    assign mem_addr_o  = in_bus ? {req_q.addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign mem_be_o    = in_bus ? lane_be : 4'b0000;
    assign mem_wdata_o = in_bus ? DATA_WIDTH'(lane_data) : '0;

    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_misalign_o = rsp_misalign_q;

endmodule

// File: tb/tb_rv32im_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv32im_dmem_ctrl
//   Self-checking bench for rv32im_dmem_ctrl (timeout shortened to 4 cycles).
//   Expected bus fields and responses come from a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_rv32im_dmem_ctrl;
    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i, req_we_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_misalign_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    rv32im_dmem_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .busy_o(busy_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_misalign_o(rsp_misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic int m_nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic bit m_mis(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'b11) || ((addr % m_nbytes(size)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] v;
        v = ((32'd1 << m_nbytes(size)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    // each bus byte k carries store byte (k mod access size)
    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = m_nbytes(size);
        r  = 0;
        for (int k = 0; k < 4; k++)
            r = r | (((wd >> (8 * (k % nb))) & 32'hFF) << (8 * k));
        return r;
    endfunction

    // ---------------- one full transaction, starts and ends on a negedge ----------------
    task automatic run_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic berr,
                           input int w, input bit junk, input string name);
        logic [3:0]  ebe;
        logic [31:0] ewd, eaddr, erd;
        logic        eerr;
        bit          mis, tmo;
        int          nbus;
        mis   = m_mis(size, addr);
        ebe   = m_be(size, addr);
        ewd   = m_wdata(size, wdata);
        eaddr = addr - (addr % 4);

        req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
        req_addr_i = addr; req_wdata_i = wdata;
        n_vec++;
        if ({req_ready_o, busy_o} !== 2'b10) begin
            n_err++;
            $display("FAIL %s/idle: ready,busy got %b exp 10", name, {req_ready_o, busy_o});
        end
        @(posedge clk_i);
        @(negedge clk_i);
        if (junk) begin
            req_we_i = ~we; req_size_i = $urandom_range(0, 3);
            req_addr_i = $urandom; req_wdata_i = $urandom;
        end else begin
            req_valid_i = 1'b0;
        end

        if (mis) begin
            req_valid_i = 1'b0;
            n_vec++;
            if ({rsp_valid_o, rsp_misalign_o, rsp_err_o, rsp_rdata_o, mem_req_o, busy_o}
                !== {1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL %s/misalign_rsp: vld,mis,err,rd,req,busy got %b %b %b %h %b %b exp 1 1 0 0 0 1",
                         name, rsp_valid_o, rsp_misalign_o, rsp_err_o, rsp_rdata_o, mem_req_o, busy_o);
            end
            // a stray ack outside BUS must be ignored
            mem_ack_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = $urandom;
            @(negedge clk_i);
            n_vec++;
            if ({rsp_valid_o, req_ready_o, busy_o, mem_req_o, rsp_misalign_o, rsp_err_o, rsp_rdata_o}
                !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
                n_err++;
                $display("FAIL %s/misalign_after: vld,rdy,busy,req,mis,err,rd got %b %b %b %b %b %b %h exp 0 1 0 0 1 0 0",
                         name, rsp_valid_o, req_ready_o, busy_o, mem_req_o, rsp_misalign_o, rsp_err_o, rsp_rdata_o);
            end
            mem_ack_i = 1'b0; mem_err_i = 1'b0;
            return;
        end

        tmo  = (w >= TMO);
        nbus = tmo ? TMO : w + 1;
        for (int c = 0; c < nbus; c++) begin
            n_vec++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o, req_ready_o, rsp_valid_o}
                !== {1'b1, we, eaddr, ebe, ewd, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL %s/bus c%0d: req,we,addr,be,wd,busy,rdy,vld got %b %b %h %b %h %b %b %b exp 1 %b %h %b %h 1 0 0",
                         name, c, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o,
                         req_ready_o, rsp_valid_o, we, eaddr, ebe, ewd);
            end
            if (c == w) begin
                mem_ack_i = 1'b1; mem_rdata_i = rdata; mem_err_i = berr;
            end
            @(negedge clk_i);
            mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = $urandom;
            if (junk) begin
                req_addr_i = $urandom; req_wdata_i = $urandom; req_size_i = $urandom_range(0, 3);
            end
        end
        req_valid_i = 1'b0;
        eerr = tmo ? 1'b1 : berr;
        erd  = (tmo || we) ? 32'h0 : rdata;
        n_vec++;
        if ({rsp_valid_o, rsp_err_o, rsp_misalign_o, rsp_rdata_o, mem_req_o, busy_o}
            !== {1'b1, eerr, 1'b0, erd, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL %s/rsp: vld,err,mis,rd,req,busy got %b %b %b %h %b %b exp 1 %b 0 %h 0 1",
                     name, rsp_valid_o, rsp_err_o, rsp_misalign_o, rsp_rdata_o, mem_req_o, busy_o, eerr, erd);
        end
        @(negedge clk_i);
        n_vec++;
        if ({rsp_valid_o, req_ready_o, busy_o, rsp_err_o, rsp_misalign_o, rsp_rdata_o}
            !== {1'b0, 1'b1, 1'b0, eerr, 1'b0, erd}) begin
            n_err++;
            $display("FAIL %s/hold: vld,rdy,busy,err,mis,rd got %b %b %b %b %b %h exp 0 1 0 %b 0 %h",
                     name, rsp_valid_o, req_ready_o, busy_o, rsp_err_o, rsp_misalign_o, rsp_rdata_o, eerr, erd);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
        req_addr_i = '0; req_wdata_i = '0; mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        n_vec++;
        if ({req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_misalign_o, rsp_rdata_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== {1'b1, 106'h0}) begin
            n_err++;
            $display("FAIL reset: rdy,busy,vld,err,mis,req,we got %b %b %b %b %b %b %b rd %h addr %h be %b wd %h exp rdy=1 rest 0",
                     req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_misalign_o, mem_req_o, mem_we_o,
                     rsp_rdata_o, mem_addr_o, mem_be_o, mem_wdata_o);
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_lw();
        run_txn(1'b0, 2'b10, 32'h100, 32'h0, 32'h000CF5BD, 1'b0, 0, 1'b0, "lw_zero_wait");
    endtask

    task automatic test_sb_wait();
        run_txn(1'b1, 2'b00, 32'h103, 32'h12345678, 32'hDEADBEEF, 1'b0, 3, 1'b0, "sb_wait3");
        run_txn(1'b1, 2'b01, 32'h102, 32'hCAFEBABE, 32'h0, 1'b0, 1, 1'b0, "sh_hi");
    endtask

    task automatic test_misalign();
        run_txn(1'b0, 2'b01, 32'h101, 32'h0, 32'h0, 1'b0, 0, 1'b0, "lh_odd");
        run_txn(1'b0, 2'b10, 32'h102, 32'h0, 32'h0, 1'b0, 0, 1'b0, "lw_102");
        run_txn(1'b0, 2'b11, 32'h100, 32'h0, 32'h0, 1'b0, 0, 1'b0, "size11");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 2'b10, 32'h200, 32'h0, 32'h11111111, 1'b0, 100, 1'b0, "timeout");
        run_txn(1'b0, 2'b10, 32'h204, 32'h0, 32'hA5A55A5A, 1'b0, TMO - 1, 1'b0, "ack_at_limit");
    endtask

    task automatic test_bus_err();
        run_txn(1'b1, 2'b10, 32'h300, 32'h87654321, 32'hFFFFFFFF, 1'b1, 2, 1'b0, "store_err");
    endtask

    task automatic test_async_reset();
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10;
        req_addr_i = 32'h400; req_wdata_i = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        n_vec++;
        if (mem_req_o !== 1'b1) begin
            n_err++;
            $display("FAIL arst/pre: mem_req got %b exp 1", mem_req_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        n_vec++;
        if ({mem_req_o, busy_o, req_ready_o, rsp_valid_o} !== 4'b0010) begin
            n_err++;
            $display("FAIL arst/async: req,busy,rdy,vld got %b exp 0010",
                     {mem_req_o, busy_o, req_ready_o, rsp_valid_o});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            n_vec++;
            if (rsp_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL arst/no_rsp%0d: rsp_valid got %b exp 0", i, rsp_valid_o);
            end
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
        run_txn(1'b0, 2'b10, 32'h404, 32'h0, 32'h13579BDF, 1'b0, 1, 1'b0, "after_arst");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom_range(0, 5), bit'($urandom_range(0, 1)),
                    $sformatf("rnd%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_txn(1'b0, 2'b00, 32'h500 + i, 32'h0, 32'h01020304 * (i + 1), 1'b0, 0, 1'b1,
                    $sformatf("b2b%0d", i));
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb_wait();
        test_misalign();
        test_timeout();
        test_bus_err();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
